multi_sel_pack: RTL and testbench

- Downstream consumer of the multiply-select stage.
- Upstream emits a repeating 4-cycle product sequence: ×1, ×3, ×7, ×8 of one sampled byte. It raises input_grant in the same cycle as the ×1 product.
- This block re-frames each sequence into one packed group word and optionally checks the arithmetic consistency of the four products.
- Groups are buffered in a small first-word-fall-through (FWFT) FIFO and delivered on a valid/ready interface.

---
 rtl/multi_sel_pack.sv | 131 +++++++++++++
 tb/tb_multi_sel_pack.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sel_pack.sv
// Purpose : packs the upstream x1/x3/x7/x8 product sequence into one group word, buffered in an FWFT FIFO.
// Latency : input_grant at cycle T -> FIFO entry written end of T+3 -> grp_valid at T+4 when the FIFO was empty.
// Backpr. : grp_valid/grp_ready handshake; a group completing into a full FIFO with no pop is dropped (sticky overflow).
// Option  : define MULTI_PACK_CHECK_EN to add the product consistency checker and the per-entry err bit.
module multi_sel_pack #(
    parameter int PW    = 11,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_grant,
    input  logic [PW-1:0]     prod_in,
    output logic [4*PW-1:0]   grp_data,
    output logic              grp_err,
    output logic              grp_valid,
    input  logic              grp_ready,
    output logic              frame_err,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          r_state;
    logic [1:0]      r_phase;
    logic [PW-1:0]   r_x1;
    logic [PW-1:0]   r_x3;
    logic [PW-1:0]   r_x7;
    logic            r_frame_err;
    logic            r_overflow;

    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [4*PW-1:0] r_mem [DEPTH];

    logic            w_last;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [4*PW-1:0] w_word;
    logic            w_err;

    // The x8 product arrives live on the last phase, so it is packed straight from prod_in.
    assign w_last = (r_state == COLLECT) && (r_phase == 2'd3) && !input_grant;
    assign w_word = {prod_in, r_x7, r_x3, r_x1};

`ifdef MULTI_PACK_CHECK_EN
    // Widened by 3 bits so 7*x1 and x1<<3 cannot alias back into range.
    localparam logic [PW+2:0] C3 = (PW+3)'(3);
    localparam logic [PW+2:0] C7 = (PW+3)'(7);
    logic [PW+2:0] w_x1e;
    logic [PW+2:0] w_x3e;
    logic [PW+2:0] w_x7e;
    logic [PW+2:0] w_x8e;
    logic          r_mem_err [DEPTH];

    assign w_x1e = {3'b000, r_x1};
    assign w_x3e = {3'b000, r_x3};
    assign w_x7e = {3'b000, r_x7};
    assign w_x8e = {3'b000, prod_in};
    assign w_err = (w_x3e != w_x1e * C3) || (w_x7e != w_x1e * C7) || (w_x8e != (w_x1e << 3));

    // Error bit storage travels alongside the data word.
    always_ff @(posedge clk) begin
        if (w_push) r_mem_err[r_wptr[AW-1:0]] <= w_err;
    end

    assign grp_err = w_empty ? 1'b0 : r_mem_err[r_rptr[AW-1:0]];
`else
    assign w_err   = 1'b0;
    assign grp_err = w_err;
`endif

    // Framing FSM: a grant always opens a new group; one arriving mid-group aborts the old one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_phase     <= 2'd0;
            r_x1        <= '0;
            r_x3        <= '0;
            r_x7        <= '0;
            r_frame_err <= 1'b0;
        end else if (input_grant) begin
            r_x1    <= prod_in;
            r_phase <= 2'd1;
            r_state <= COLLECT;
            if (r_state == COLLECT) r_frame_err <= 1'b1;
        end else if (r_state == COLLECT) begin
            case (r_phase)
                2'd1:    r_x3 <= prod_in;
                2'd2:    r_x7 <= prod_in;
                default: r_state <= IDLE;
            endcase
            r_phase <= r_phase + 2'd1;
        end
    end

    // FIFO occupancy from extra-MSB pointers; a pop frees the slot a same-cycle push needs.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && grp_ready;
    assign w_push  = w_last && (!w_full || w_pop);
    assign w_drop  = w_last && w_full && !w_pop;

    // Data storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_word;
    end

    // Pointer and sticky overflow bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign grp_valid = !w_empty;
    assign grp_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_multi_sel_pack.sv
`timescale 1ns/1ps
module tb_multi_sel_pack;

    localparam int PW    = 11;
    localparam int DEPTH = 4;
`ifdef MULTI_PACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            input_grant;
    logic [PW-1:0]   prod_in;
    logic [4*PW-1:0] grp_data;
    logic            grp_err;
    logic            grp_valid;
    logic            grp_ready;
    logic            frame_err;
    logic            overflow;

    multi_sel_pack #(.PW(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .input_grant(input_grant), .prod_in(prod_in),
        .grp_data(grp_data), .grp_err(grp_err), .grp_valid(grp_valid),
        .grp_ready(grp_ready), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a list of captured products for the open group and a queue of delivered groups.
    typedef struct { logic [4*PW-1:0] dat; logic err; } ent_t;
    ent_t m_q[$];
    int   m_g[4];
    int   m_cnt = 0;
    logic m_fe  = 1'b0;
    logic m_ov  = 1'b0;

    function automatic logic [4*PW-1:0] pack4(int a, int b, int c, int d);
        return {d[PW-1:0], c[PW-1:0], b[PW-1:0], a[PW-1:0]};
    endfunction

    function automatic logic calc_err(int a, int b, int c, int d);
        return CHK && ((b != 3*a) || (c != 7*a) || (d != 8*a));
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_cnt = 0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
    endtask

    task automatic model_update(input logic g, input int p, input logic r);
        ent_t e;
        if (m_q.size() > 0 && r) void'(m_q.pop_front());
        if (g) begin
            if (m_cnt != 0) m_fe = 1'b1;
            m_g[0] = p;
            m_cnt  = 1;
        end else if (m_cnt != 0) begin
            m_g[m_cnt] = p;
            m_cnt++;
            if (m_cnt == 4) begin
                e.dat = pack4(m_g[0], m_g[1], m_g[2], m_g[3]);
                e.err = calc_err(m_g[0], m_g[1], m_g[2], m_g[3]);
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else m_ov = 1'b1;
                m_cnt = 0;
            end
        end
    endtask

    // One clock: drive inputs, let the DUT and model advance, return at the next falling edge.
    task automatic step(input logic g, input int p, input logic r);
        input_grant = g;
        prod_in     = p[PW-1:0];
        grp_ready   = r;
        @(posedge clk);
        model_update(g, p, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; input_grant = 1'b0; prod_in = '0; grp_ready = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic group(input int d, input logic r);
        step(1'b1, d, r);
        step(1'b0, 3*d, r);
        step(1'b0, 7*d, r);
        step(1'b0, 8*d, r);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; input_grant = 1'b0; prod_in = '0; grp_ready = 1'b0;
        model_clear();
        #1;
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", grp_valid); else n_pass++;
        n_checks++; if (grp_data !== '0) $display("FAIL reset_data got=%h exp=0", grp_data); else n_pass++;
        n_checks++; if (grp_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", grp_err); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%0b exp=0", frame_err); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0b exp=0", overflow); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency_ff();
        do_reset();
        step(1'b1, 255, 1'b1);
        step(1'b0, 765, 1'b1);
        step(1'b0, 1785, 1'b1);
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL ff_early_valid got=%0b exp=0", grp_valid); else n_pass++;
        step(1'b0, 2040, 1'b1);
        n_checks++; if (grp_valid !== 1'b1) $display("FAIL ff_valid got=%0b exp=1", grp_valid); else n_pass++;
        n_checks++; if (grp_data !== pack4(255, 765, 1785, 2040)) $display("FAIL ff_data got=%h exp=%h", grp_data, pack4(255, 765, 1785, 2040)); else n_pass++;
        n_checks++; if (grp_err !== 1'b0) $display("FAIL ff_err got=%0b exp=0", grp_err); else n_pass++;
        step(1'b0, 0, 1'b1);
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL ff_one_cycle got=%0b exp=0", grp_valid); else n_pass++;
    endtask

    task automatic test_check_err();
        do_reset();
        step(1'b1, 10, 1'b1);
        step(1'b0, 30, 1'b1);
        step(1'b0, 71, 1'b1);
        step(1'b0, 80, 1'b1);
        n_checks++; if (grp_data !== pack4(10, 30, 71, 80)) $display("FAIL err_data got=%h exp=%h", grp_data, pack4(10, 30, 71, 80)); else n_pass++;
        n_checks++; if (grp_err !== CHK) $display("FAIL err_flag got=%0b exp=%0b", grp_err, CHK); else n_pass++;
    endtask

    task automatic test_abort();
        do_reset();
        step(1'b1, 10, 1'b1);
        step(1'b0, 30, 1'b1);
        step(1'b1, 5, 1'b1);
        n_checks++; if (frame_err !== 1'b1) $display("FAIL abort_frame_err got=%0b exp=1", frame_err); else n_pass++;
        step(1'b0, 15, 1'b1);
        step(1'b0, 35, 1'b1);
        step(1'b0, 40, 1'b1);
        n_checks++; if (grp_valid !== 1'b1) $display("FAIL abort_valid got=%0b exp=1", grp_valid); else n_pass++;
        n_checks++; if (grp_data !== pack4(5, 15, 35, 40)) $display("FAIL abort_data got=%h exp=%h", grp_data, pack4(5, 15, 35, 40)); else n_pass++;
        step(1'b0, 0, 1'b1);
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL abort_single got=%0b exp=0", grp_valid); else n_pass++;
        n_checks++; if (frame_err !== 1'b1) $display("FAIL abort_sticky got=%0b exp=1", frame_err); else n_pass++;
    endtask

    task automatic test_overflow();
        int got;
        do_reset();
        for (int d = 1; d <= 5; d++) begin
            group(d, 1'b0);
            if (d == 4) begin
                n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early got=%0b exp=0", overflow); else n_pass++;
            end
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow); else n_pass++;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (grp_valid === 1'b1) begin
                got++;
                n_checks++; if (grp_data !== pack4(got, 3*got, 7*got, 8*got)) $display("FAIL ovf_order%0d got=%h exp=%h", got, grp_data, pack4(got, 3*got, 7*got, 8*got)); else n_pass++;
            end
            step(1'b0, 0, 1'b1);
        end
        n_checks++; if (got !== 4) $display("FAIL ovf_count got=%0d exp=4", got); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        int got;
        do_reset();
        for (int d = 1; d <= 4; d++) group(d, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b0, 15, 1'b0);
        step(1'b0, 35, 1'b0);
        step(1'b0, 40, 1'b1);
        step(1'b0, 0, 1'b0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow got=%0b exp=0", overflow); else n_pass++;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (grp_valid === 1'b1) begin
                got++;
                n_checks++; if (grp_data !== pack4(got+1, 3*(got+1), 7*(got+1), 8*(got+1))) $display("FAIL pp_order%0d got=%h exp=%h", got, grp_data, pack4(got+1, 3*(got+1), 7*(got+1), 8*(got+1))); else n_pass++;
            end
            step(1'b0, 0, 1'b1);
        end
        n_checks++; if (got !== 4) $display("FAIL pp_count got=%0d exp=4", got); else n_pass++;
    endtask

    task automatic test_reset_mid_group();
        do_reset();
        group(1, 1'b0);
        group(2, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b0, 9, 1'b0);
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL rmid_valid got=%0b exp=0", grp_valid); else n_pass++;
        n_checks++; if (grp_data !== '0) $display("FAIL rmid_data got=%h exp=0", grp_data); else n_pass++;
        n_checks++; if (grp_err !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0)
            $display("FAIL rmid_flags got=%0b%0b%0b exp=000", grp_err, frame_err, overflow); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        group(9, 1'b1);
        n_checks++; if (grp_valid !== 1'b1) $display("FAIL rmid_next_valid got=%0b exp=1", grp_valid); else n_pass++;
        n_checks++; if (grp_data !== pack4(9, 27, 63, 72)) $display("FAIL rmid_next_data got=%h exp=%h", grp_data, pack4(9, 27, 63, 72)); else n_pass++;
        step(1'b0, 0, 1'b1);
        n_checks++; if (grp_valid !== 1'b0) $display("FAIL rmid_only got=%0b exp=0", grp_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic g_q[$];
        int   p_q[$];
        int   vals[4];
        int   len;
        int   d;
        logic rdy;
        int   bad;
        do_reset();
        for (int n = 0; n < 250; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g_q.push_back(1'b0);
                p_q.push_back(int'($urandom_range(0, 2047)));
            end
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
            d = int'($urandom_range(0, 255));
            vals[0] = d; vals[1] = 3*d; vals[2] = 7*d; vals[3] = 8*d;
            if ($urandom_range(0, 3) == 0) begin
                bad = int'($urandom_range(1, 3));
                vals[bad] = int'($urandom_range(0, 2047));
            end
            for (int i = 0; i < len; i++) begin
                g_q.push_back(i == 0);
                p_q.push_back(vals[i]);
            end
        end
        for (int c = 0; c < g_q.size(); c++) begin
            rdy = ((c / 64) % 3 == 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
            step(g_q[c], p_q[c], rdy);
            n_checks++; if (grp_valid !== (m_q.size() != 0)) $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, grp_valid, m_q.size() != 0); else n_pass++;
            if (m_q.size() != 0) begin
                n_checks++; if (grp_data !== m_q[0].dat) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, grp_data, m_q[0].dat); else n_pass++;
                n_checks++; if (grp_err !== m_q[0].err) $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, grp_err, m_q[0].err); else n_pass++;
            end
            n_checks++; if (frame_err !== m_fe) $display("FAIL rnd_frame_err c=%0d got=%0b exp=%0b", c, frame_err, m_fe); else n_pass++;
            n_checks++; if (overflow !== m_ov) $display("FAIL rnd_overflow c=%0d got=%0b exp=%0b", c, overflow, m_ov); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0; input_grant = 1'b0; prod_in = '0; grp_ready = 1'b0;
        test_reset();
        test_latency_ff();
        test_check_err();
        test_abort();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_group();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
